// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage (master) and imem (slave).
interface fetch_stage_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;

  modport master (
    output o_imem_req, o_imem_addr,
    input  i_imem_gnt, i_imem_rvalid, i_imem_rdata
  );

  modport slave (
    input  o_imem_req, o_imem_addr,
    output i_imem_gnt, i_imem_rvalid, i_imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: credit-limited in-order imem requests, PC-tagged fetch buffer, flush/redirect.
// Optional same-cycle response bypass to decode when FETCH_BYPASS_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic [31:0]        i_redirect_pc,
  fetch_stage_if.master      imem,
  output logic               o_if_valid,
  output logic [31:0]        o_if_pc,
  output logic [31:0]        o_if_instr
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q,  resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q    [FIFO_DEPTH];
  logic [31:0]   instr_mem_q [FIFO_DEPTH];

  logic fifo_empty_c, credit_ok_c, req_c, gnt_fire_c;
  logic resp_keep_c, resp_drop_c, bypass_c, push_c, pop_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake, credit and output decode
  always_comb begin
    fifo_empty_c = (count_q == '0);
    credit_ok_c  = ({1'b0, outstanding_q} + {1'b0, count_q}) < (CW + 1)'(FIFO_DEPTH);
    req_c        = rst_n && !i_flush && credit_ok_c;
    gnt_fire_c   = req_c && imem.i_imem_gnt;
    resp_drop_c  = imem.i_imem_rvalid && (drop_cnt_q != '0);
    resp_keep_c  = imem.i_imem_rvalid && (drop_cnt_q == '0);
`ifdef FETCH_BYPASS_EN
    bypass_c     = fifo_empty_c && resp_keep_c;
`else
    bypass_c     = 1'b0;
`endif
    pop_c        = !fifo_empty_c && !i_flush && !i_stall;
    push_c       = resp_keep_c && !i_flush && !(bypass_c && !i_stall);

    imem.o_imem_req  = req_c;
    imem.o_imem_addr = fetch_pc_q;
    o_if_valid       = !i_flush && (!fifo_empty_c || bypass_c);
    if (!fifo_empty_c) begin
      o_if_pc    = pc_mem_q[rd_ptr_q];
      o_if_instr = instr_mem_q[rd_ptr_q];
    end else if (bypass_c) begin
      o_if_pc    = resp_pc_q;
      o_if_instr = imem.i_imem_rdata;
    end else begin
      o_if_pc    = '0;
      o_if_instr = '0;
    end
  end

  // Next-state: flush overrides every other update
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (i_flush) begin
      fetch_pc_d    = {i_redirect_pc[31:2], 2'b00};
      resp_pc_d     = {i_redirect_pc[31:2], 2'b00};
      outstanding_d = outstanding_q - CW'(imem.i_imem_rvalid);
      drop_cnt_d    = outstanding_q - CW'(imem.i_imem_rvalid);
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
    end else begin
      if (gnt_fire_c)  fetch_pc_d = fetch_pc_q + 32'd4;
      if (resp_keep_c) resp_pc_d  = resp_pc_q + 32'd4;
      if (resp_drop_c) drop_cnt_d = drop_cnt_q - CW'(1);
      outstanding_d = outstanding_q + CW'(gnt_fire_c) - CW'(imem.i_imem_rvalid);
      if (push_c) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_c)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Buffer storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push_c) begin
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
      instr_mem_q[wr_ptr_q] <= imem.i_imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: imem model with in-order delayed responses, scoreboard of fetched words.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] rpc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_redirect_pc(rpc),
    .imem         (bus),
    .o_if_valid   (if_valid),
    .o_if_pc      (if_pc),
    .o_if_instr   (if_instr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int cyc; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t        memq[$];   // granted, response not yet returned
  ent_t        fq[$];     // words fetched for the current PC stream, not yet consumed
  logic [31:0] m_fetch_pc;
  int          epoch;
  int          cyc;
  int unsigned checks;
  int unsigned errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    memq.delete();
    fq.delete();
    m_fetch_pc = RST_PC;
    epoch++;
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, update model at next posedge+1
  task automatic step(input int stall_pct, input bit do_flush, input logic [31:0] redir,
                      input int gnt_pct, input int rv_pct);
    logic rv, gnt, stale, keep, byp, e_req, e_valid;
    logic [31:0] e_pc, e_instr;
    req_t r;
    rv    = (memq.size() > 0) && (memq[0].cyc < cyc) && ($urandom_range(99) < 32'(rv_pct));
    gnt   = $urandom_range(99) < 32'(gnt_pct);
    stall = $urandom_range(99) < 32'(stall_pct);
    flush = do_flush;
    rpc   = redir;
    bus.i_imem_gnt    = gnt;
    bus.i_imem_rvalid = rv;
    bus.i_imem_rdata  = rv ? (memq[0].addr ^ KEY) : $urandom;

    @(negedge clk);
    stale = rv && (memq[0].epoch != epoch);
    keep  = rv && !stale;
`ifdef FETCH_BYPASS_EN
    byp = (fq.size() == 0) && keep;
`else
    byp = 1'b0;
`endif
    e_req   = !flush && (memq.size() + fq.size() < DEPTH);
    e_valid = !flush && (fq.size() > 0 || byp);
    if (fq.size() > 0) begin
      e_pc = fq[0].pc;  e_instr = fq[0].instr;
    end else if (byp) begin
      e_pc = memq[0].addr;  e_instr = memq[0].addr ^ KEY;
    end else begin
      e_pc = '0;  e_instr = '0;
    end
    check("imem_req",  32'(bus.o_imem_req), 32'(e_req));
    check("imem_addr", bus.o_imem_addr, m_fetch_pc);
    check("if_valid",  32'(if_valid), 32'(e_valid));
    check("if_pc",     if_pc, e_pc);
    check("if_instr",  if_instr, e_instr);

    @(posedge clk);
    #1;
    if (e_valid && !stall && fq.size() > 0) void'(fq.pop_front());
    if (rv) begin
      r = memq.pop_front();
      if (keep && !flush && !(byp && !stall)) fq.push_back('{r.addr, r.addr ^ KEY});
    end
    if (flush) begin
      fq.delete();
      epoch++;
      m_fetch_pc = {redir[31:2], 2'b00};
    end else if (e_req && gnt) begin
      memq.push_back('{m_fetch_pc, epoch, cyc});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    cyc++;
  endtask

  function automatic logic [31:0] rand_redir();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(3) == 0) r = 32'hFFFF_FFF0 | (r & 32'h0000_000F);
    return r;
  endfunction

  task automatic drain();
    for (int i = 0; i < 8; i++) step(0, 1'b0, 32'h0, 0, 100);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    epoch  = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    stall  = 1'b0;
    flush  = 1'b0;
    rpc    = '0;
    bus.i_imem_gnt    = 1'b0;
    bus.i_imem_rvalid = 1'b0;
    bus.i_imem_rdata  = '0;
    model_reset();
    #1;
    check("rst_req",   32'(bus.o_imem_req), 32'h0);
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_pc",    if_pc, 32'h0);
    check("rst_instr", if_instr, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // streaming, then decode stall, then release
    for (int i = 0; i < 12; i++) step(0, 1'b0, 32'h0, 100, 100);
    for (int i = 0; i < 5; i++)  step(100, 1'b0, 32'h0, 100, 100);
    for (int i = 0; i < 6; i++)  step(0, 1'b0, 32'h0, 100, 100);

    // grant backpressure
    drain();
    for (int i = 0; i < 3; i++) step(0, 1'b0, 32'h0, 0, 100);

    // flush with two outstanding; stale responses arrive afterwards
    step(0, 1'b0, 32'h0, 100, 0);
    step(0, 1'b0, 32'h0, 100, 0);
    step(0, 1'b0, 32'h0, 100, 0);
    step(0, 1'b1, 32'h0000_2002, 100, 0);
    for (int i = 0; i < 8; i++) step(0, 1'b0, 32'h0, 100, 100);

    // flush coinciding with the only outstanding response
    drain();
    step(0, 1'b0, 32'h0, 100, 0);
    step(0, 1'b1, 32'h0000_3000, 0, 100);
    for (int i = 0; i < 6; i++) step(0, 1'b0, 32'h0, 100, 100);

    // back-to-back flushes and PC wrap at the top of memory
    step(0, 1'b1, 32'h0000_4000, 100, 100);
    step(0, 1'b1, 32'hFFFF_FFF5, 100, 100);
    for (int i = 0; i < 8; i++) step(0, 1'b0, 32'h0, 100, 100);

    for (int i = 0; i < 1500; i++)
      step(30, ($urandom_range(99) < 4), rand_redir(), 70, 60);

    // asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    bus.i_imem_gnt    = 1'b0;
    bus.i_imem_rvalid = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    #1;
    check("midrst_req",   32'(bus.o_imem_req), 32'h0);
    check("midrst_valid", 32'(if_valid), 32'h0);
    check("midrst_pc",    if_pc, 32'h0);
    check("midrst_instr", if_instr, 32'h0);
    check("midrst_addr",  bus.o_imem_addr, RST_PC);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(0, 1'b0, 32'h0, 100, 100);
    for (int i = 0; i < 500; i++)
      step(30, ($urandom_range(99) < 4), rand_redir(), 70, 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
